uart_fifo_feeder: RTL and testbench
===================================

Name: uart_fifo_feeder

Overview:
Sequencer directly upstream of the UART transmitter. It pops bytes from the sample FIFO and presents each one as a parallel byte plus a start request, then waits for the transmitter's send-status flag to complete a full frame before fetching the next byte. It also provides a frame counter, a busy indication and a sticky handshake-timeout error.

Parameters:
FIFO_LAT, 1, FIFO read latency in cycles from the rdreq cycle to valid fifo_q (legal values 1 or 2).
START_TIMEOUT, 16, maximum cycles in START waiting for send_sta_flg to go high.
GAP_CYCLES, 4, idle cycles between frames; values below 2 are treated as 2.

Ports:
sysclk_12  in  1  system clock (12 MHz).
i_rest  in  1  asynchronous reset, active-high.
tx_enable  in  1  level; 1 allows new frames to start.
rdempty  in  1  FIFO empty flag.
fifo_q  in  8  FIFO read data.
rdreq  out  1  FIFO read request, registered, one-cycle pulse per byte.
paralle_data  out  8  byte to the transmitter, registered.
uart_en  out  1  start request to the transmitter, registered level.
send_sta_flg  in  1  transmitter busy flag; 1 while a frame is in progress.
busy  out  1  1 in any state other than IDLE.
byte_cnt  out  16  frames handed off successfully; wraps from 0xFFFF to 0.
err_timeout  out  1  sticky; set when START times out.
err_clr  in  1  one-cycle pulse that clears err_timeout.

Behaviour:
- Reset: i_rest=1 forces the following immediately, without waiting for a clock edge: state=IDLE, rdreq=0, uart_en=0, paralle_data=0, busy=0, byte_cnt=0, err_timeout=0, all counters=0.
- Reset mid-frame abandons the frame. uart_en drops at once, so the transmitter finishes any frame it has already latched on its own.
- FSM states: IDLE, RD_REQ, RD_WAIT, START, BUSY, GAP.
- IDLE -> RD_REQ when tx_enable=1 and rdempty=0, sampled at the clock edge. Otherwise stay in IDLE.
- RD_REQ: rdreq=1 for exactly this one cycle. Next state is RD_WAIT.
- RD_WAIT: lasts FIFO_LAT cycles. On the exit edge, paralle_data <= fifo_q and the state moves to START.
- Latency: uart_en is first high FIFO_LAT+2 cycles after the IDLE decision edge.
- START: uart_en=1 and a timeout counter increments each cycle.
  - If send_sta_flg=1: uart_en <= 0, byte_cnt <= byte_cnt+1, go to BUSY.
  - Else if the counter reaches START_TIMEOUT-1: uart_en <= 0, err_timeout <= 1, go to GAP. The byte is dropped and not counted.
- paralle_data holds its value from the START entry edge until the next RD_WAIT exit. The transmitter samples it two to three cycles after uart_en rises.
- BUSY: uart_en=0. Go to GAP on the first cycle with send_sta_flg=0.
- GAP: count max(GAP_CYCLES,2) cycles, then go to IDLE. This guarantees uart_en is low for at least 2 cycles, so the transmitter's edge detector sees every start request.
- tx_enable=0 only gates the IDLE exit. A frame already in RD_REQ through GAP always completes.
- rdempty is sampled only in IDLE. rdreq is never asserted while rdempty=1 at the decision edge, and this block is the sole FIFO reader.
- err_clr=1 clears err_timeout. If err_clr and a new timeout occur in the same cycle, set wins.
- byte_cnt increments exactly once per accepted frame and wraps without saturation.
- busy is a registered decode: 1 in every state except IDLE.
- Throughput: at most one byte per (FIFO_LAT+2 + handshake + frame time + GAP) cycles. There is no pipelining across frames.

Test Plan:
1. Single byte: FIFO holds 0xA5, tx_enable=1, behavioural transmitter (BIT_CNT=104) -> one rdreq pulse, paralle_data=0xA5 stable while uart_en is high, serial line carries start, 10100101 LSB-first, stop; byte_cnt=1; busy returns to 0.
2. Burst: FIFO holds 0x00, 0xFF, 0x3C -> three frames in order; uart_en low for at least GAP_CYCLES cycles between frames; byte_cnt=3; no rdreq after rdempty=1.
3. Timeout: send_sta_flg tied to 0, one byte 0x55 -> uart_en high exactly 16 cycles, then err_timeout=1, byte_cnt=0. err_clr pulse -> err_timeout=0. Same-cycle err_clr and timeout -> err_timeout stays 1.
4. Enable gating: drop tx_enable while in BUSY with 2 bytes still queued -> current frame completes, no further rdreq until tx_enable=1, then the remaining bytes go out.
5. Reset mid-frame: assert i_rest during BUSY -> all outputs 0 asynchronously in that same cycle. After release with FIFO non-empty, normal operation resumes and byte_cnt counts from 0.
6. Wrap and latency: preload byte_cnt to 0xFFFF (force), send one byte -> byte_cnt=0x0000. Rerun with FIFO_LAT=2 -> paralle_data equals the FIFO word and uart_en rises 4 cycles after the IDLE decision edge.

Source files
------------

// File: rtl/uart_fifo_feeder.sv
// rtl/uart_fifo_feeder.sv - pops FIFO bytes and hands them to the UART transmitter one frame at a time
// Registered outputs are derived from the next state so they change on the same edge as the FSM.
module uart_fifo_feeder #(
  parameter int FIFO_LAT      = 1,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        sysclk_12,
  input  logic        i_rest,
  input  logic        tx_enable,
  input  logic        rdempty,
  input  logic [7:0]  fifo_q,
  output logic        rdreq,
  output logic [7:0]  paralle_data,
  output logic        uart_en,
  input  logic        send_sta_flg,
  output logic        busy,
  output logic [15:0] byte_cnt,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam int          GAP_EFF  = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
  localparam logic [15:0] LAT_LAST = 16'(FIFO_LAT - 1);
  localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    START   = 3'd3,
    BUSY    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_rdreq;
  logic        r_uart_en;
  logic        r_busy;
  logic        r_err;
  logic [7:0]  r_data;
  logic [15:0] r_byte_cnt;
  logic        w_accept;
  logic        w_timeout;

  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:    if (tx_enable && !rdempty) w_next = RD_REQ;
      RD_REQ:  w_next = RD_WAIT;
      RD_WAIT: if (r_cnt == LAT_LAST) w_next = START;
      START: begin
        if (send_sta_flg) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = GAP;
        end
      end
      BUSY:    if (!send_sta_flg) w_next = GAP;
      GAP:     if (r_cnt == GAP_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One shared cycle counter, restarted on every state change (RD_WAIT, START and GAP use it).
  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      r_cnt      <= '0;
      r_rdreq    <= 1'b0;
      r_uart_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_data     <= '0;
      r_byte_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cnt     <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      r_rdreq   <= (w_next == RD_REQ);
      r_uart_en <= (w_next == START);
      r_busy    <= (w_next != IDLE);
      if (r_state == RD_WAIT && w_next == START) r_data <= fifo_q;
      if (w_accept) r_byte_cnt <= r_byte_cnt + 16'd1;
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign rdreq        = r_rdreq;
  assign uart_en      = r_uart_en;
  assign busy         = r_busy;
  assign paralle_data = r_data;
  assign byte_cnt     = r_byte_cnt;
  assign err_timeout  = r_err;

endmodule

// File: tb/tb_uart_fifo_feeder.sv
// tb/tb_uart_fifo_feeder.sv - directed bench for uart_fifo_feeder with FIFO, transmitter and serial receiver models
module tb_uart_fifo_feeder;
  localparam int BIT_CNT = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        tx_enable = 1'b0;
  logic        err_clr = 1'b0;
  logic        rdempty;
  logic [7:0]  fifo_q = 8'h00;
  logic        rdreq, uart_en, busy, err_timeout;
  logic [7:0]  pd;
  logic [15:0] byte_cnt;
  logic        send_sta_flg = 1'b0;

  logic        tx_enable2 = 1'b0;
  logic        err_clr2 = 1'b0;
  logic        rdempty2;
  logic [7:0]  fifo_q2 = 8'h00;
  logic [7:0]  s1_2 = 8'h00;
  logic        rdreq2, uart_en2, busy2, err_timeout2;
  logic [7:0]  pd2;
  logic [15:0] byte_cnt2;
  logic        flg2 = 1'b0;

  int tests = 0;
  int fails = 0;

  uart_fifo_feeder #(.FIFO_LAT(1), .START_TIMEOUT(16), .GAP_CYCLES(4)) dut (
    .sysclk_12(clk), .i_rest(rst), .tx_enable(tx_enable), .rdempty(rdempty), .fifo_q(fifo_q),
    .rdreq(rdreq), .paralle_data(pd), .uart_en(uart_en), .send_sta_flg(send_sta_flg),
    .busy(busy), .byte_cnt(byte_cnt), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  uart_fifo_feeder #(.FIFO_LAT(2), .START_TIMEOUT(16), .GAP_CYCLES(1)) dut2 (
    .sysclk_12(clk), .i_rest(rst), .tx_enable(tx_enable2), .rdempty(rdempty2), .fifo_q(fifo_q2),
    .rdreq(rdreq2), .paralle_data(pd2), .uart_en(uart_en2), .send_sta_flg(flg2),
    .busy(busy2), .byte_cnt(byte_cnt2), .err_timeout(err_timeout2), .err_clr(err_clr2)
  );

  // FIFO models: latency 1 for dut, latency 2 for dut2
  logic [7:0] fmem [0:63];
  logic [7:0] fmem2 [0:63];
  int wp = 0, rp = 0, wp2 = 0, rp2 = 0;
  assign rdempty  = (wp == rp);
  assign rdempty2 = (wp2 == rp2);

  always @(posedge clk) begin
    if (rdreq) begin
      fifo_q <= fmem[rp % 64];
      rp     <= rp + 1;
    end
    if (rdreq2) begin
      s1_2 <= fmem2[rp2 % 64];
      rp2  <= rp2 + 1;
    end
    fifo_q2 <= s1_2;
  end

  // Transmitter model: not reset, so a latched frame always completes
  logic       txd = 1'b1;
  logic       en_d = 1'b0, tx_active = 1'b0, tx_pend = 1'b0, tx_allow = 1'b1;
  int         tx_dly = 0, tx_cnt = 0;
  logic [3:0] tx_bit = 4'd0;
  logic [9:0] tx_sh = '1;

  always @(posedge clk) begin
    en_d <= uart_en;
    if (tx_active) begin
      if (tx_cnt == BIT_CNT - 1) begin
        tx_cnt <= 0;
        if (tx_bit == 4'd9) begin
          tx_active    <= 1'b0;
          send_sta_flg <= 1'b0;
          txd          <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          tx_sh  <= tx_sh >> 1;
          txd    <= tx_sh[1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end else if (tx_pend) begin
      if (tx_dly <= 1) begin
        tx_pend      <= 1'b0;
        tx_active    <= 1'b1;
        send_sta_flg <= 1'b1;
        tx_sh        <= {1'b1, pd, 1'b0};
        txd          <= 1'b0;
        tx_cnt       <= 0;
        tx_bit       <= 4'd0;
      end else begin
        tx_dly <= tx_dly - 1;
      end
    end else if (tx_allow && uart_en && !en_d) begin
      tx_pend <= 1'b1;
      tx_dly  <= 2;
    end
  end

  // Serial receiver: mid-bit sampling, logs bytes and framing errors
  logic       rx_prev = 1'b1, rx_busy = 1'b0;
  int         rx_cnt = 0, rx_wp = 0, rx_ferr = 0;
  logic [3:0] rx_bit = 4'd0;
  logic [8:0] rx_sh = '0;
  logic [7:0] rx_mem [0:63];

  always @(posedge clk) begin
    rx_prev <= txd;
    if (!rx_busy) begin
      if (rx_prev && !txd) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
        rx_bit  <= 4'd0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == BIT_CNT / 2 + int'(rx_bit) * BIT_CNT) begin
        if (rx_bit == 4'd9) begin
          rx_mem[rx_wp % 64] <= rx_sh[8:1];
          if (rx_sh[0] !== 1'b0 || txd !== 1'b1) rx_ferr <= rx_ferr + 1;
          rx_wp   <= rx_wp + 1;
          rx_busy <= 1'b0;
        end else begin
          rx_sh[rx_bit] <= txd;
          rx_bit        <= rx_bit + 4'd1;
        end
      end
    end
  end

  // Observation of dut's handshake: rdreq pulses, uart_en rises, data stability, low-gap lengths
  int         rdreq_pulses = 0, en_rises = 0, low_run = 0, pd_changes = 0;
  int         gap_len [0:63];
  logic [7:0] pd_rise [0:63];
  logic       en_prev = 1'b0;
  logic [7:0] pd_prev = 8'h00;

  always @(negedge clk) begin
    if (rdreq === 1'b1) rdreq_pulses <= rdreq_pulses + 1;
    if (uart_en === 1'b1 && !en_prev) begin
      pd_rise[en_rises % 64] <= pd;
      gap_len[en_rises % 64] <= low_run;
      en_rises               <= en_rises + 1;
    end
    if (uart_en === 1'b1 && en_prev && pd !== pd_prev) pd_changes <= pd_changes + 1;
    low_run <= (uart_en === 1'b1) ? 0 : low_run + 1;
    en_prev <= (uart_en === 1'b1);
    pd_prev <= pd;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp % 64] = b;
    wp = wp + 1;
  endtask

  task automatic push2(input logic [7:0] b);
    fmem2[wp2 % 64] = b;
    wp2 = wp2 + 1;
  endtask

  task automatic apply_reset;
    tx_enable = 1'b0;
    tx_enable2 = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic wait_rx(input int target);
    int n = 0;
    while (rx_wp < target && n < 20000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({rdreq, uart_en, busy, err_timeout, pd, byte_cnt} !== 28'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdreq=%b uart_en=%b busy=%b err=%b data=%h cnt=%h, required all 0", rdreq, uart_en, busy, err_timeout, pd, byte_cnt);
    end
    tests++;
    if ({rdreq2, uart_en2, busy2, err_timeout2, pd2, byte_cnt2} !== 28'd0) begin
      fails++;
      $display("FAIL reset_outputs2: got busy=%b cnt=%h err=%b, required all 0", busy2, byte_cnt2, err_timeout2);
    end
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    int base_rx, base_rq, base_pc, base_rise, c, n;
    apply_reset();
    base_rx = rx_wp; base_rq = rdreq_pulses; base_pc = pd_changes; base_rise = en_rises;
    tx_enable = 1'b1;
    push(8'hA5);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin tick(1); n++; end
    tests++;
    if (rdreq !== 1'b1) begin fails++; $display("FAIL single_rdreq_first_cycle: got %b, required 1", rdreq); end
    c = 1;
    while (uart_en !== 1'b1 && c < 20) begin tick(1); c++; end
    tests++;
    if (c !== 3) begin fails++; $display("FAIL single_latency: uart_en in cycle %0d, required 3", c); end
    wait_rx(base_rx + 1);
    wait_idle();
    tick(20);
    tests++;
    if (rx_wp !== base_rx + 1 || rx_mem[base_rx % 64] !== 8'hA5) begin
      fails++; $display("FAIL single_serial: got %0d frames byte %h, required 1 frame byte a5", rx_wp - base_rx, rx_mem[base_rx % 64]);
    end
    tests++;
    if (rx_ferr !== 0) begin fails++; $display("FAIL single_framing: got %0d framing errors, required 0", rx_ferr); end
    tests++;
    if (pd_rise[base_rise % 64] !== 8'hA5 || pd_changes !== base_pc) begin
      fails++; $display("FAIL single_data_stable: data at start %h changes %0d, required a5 and 0", pd_rise[base_rise % 64], pd_changes - base_pc);
    end
    tests++;
    if (byte_cnt !== 16'd1) begin fails++; $display("FAIL single_byte_cnt: got %0d, required 1", byte_cnt); end
    tests++;
    if (busy !== 1'b0 || rdreq_pulses !== base_rq + 1) begin
      fails++; $display("FAIL single_idle: busy %b rdreq pulses %0d, required 0 and 1", busy, rdreq_pulses - base_rq);
    end
  endtask

  task automatic test_burst;
    int base_rx, base_rq, base_pc, base_rise;
    logic [7:0] exp [0:2];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    apply_reset();
    base_rx = rx_wp; base_rq = rdreq_pulses; base_pc = pd_changes; base_rise = en_rises;
    tx_enable = 1'b1;
    for (int i = 0; i < 3; i++) push(exp[i]);
    wait_rx(base_rx + 3);
    wait_idle();
    tick(50);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rx_mem[(base_rx + i) % 64] !== exp[i] || pd_rise[(base_rise + i) % 64] !== exp[i]) begin
        fails++; $display("FAIL burst_byte%0d: serial %h data %h, required %h", i, rx_mem[(base_rx + i) % 64], pd_rise[(base_rise + i) % 64], exp[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (gap_len[(base_rise + i) % 64] < 4) begin
        fails++; $display("FAIL burst_gap%0d: uart_en low %0d cycles, required at least 4", i, gap_len[(base_rise + i) % 64]);
      end
    end
    tests++;
    if (byte_cnt !== 16'd3 || rx_wp !== base_rx + 3) begin
      fails++; $display("FAIL burst_count: byte_cnt %0d frames %0d, required 3 and 3", byte_cnt, rx_wp - base_rx);
    end
    tests++;
    if (rdreq_pulses !== base_rq + 3 || rdempty !== 1'b1 || pd_changes !== base_pc || rx_ferr !== 0) begin
      fails++; $display("FAIL burst_rdreq: pulses %0d rdempty %b data changes %0d ferr %0d, required 3 1 0 0", rdreq_pulses - base_rq, rdempty, pd_changes - base_pc, rx_ferr);
    end
  endtask

  task automatic test_timeout;
    int base_rx, h, n;
    apply_reset();
    base_rx = rx_wp;
    tx_allow = 1'b0;
    tx_enable = 1'b1;
    push(8'h55);
    n = 0;
    while (uart_en !== 1'b1 && n < 20) begin tick(1); n++; end
    h = 0;
    while (uart_en === 1'b1 && h < 40) begin tick(1); h++; end
    tests++;
    if (h !== 16) begin fails++; $display("FAIL timeout_uart_en_len: high %0d cycles, required 16", h); end
    tests++;
    if (err_timeout !== 1'b1 || byte_cnt !== 16'd0) begin
      fails++; $display("FAIL timeout_flag: err %b byte_cnt %0d, required 1 and 0", err_timeout, byte_cnt);
    end
    wait_idle();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tests++;
    if (err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b, required 0", err_timeout); end
    push(8'h55);
    n = 0;
    while (uart_en !== 1'b1 && n < 20) begin tick(1); n++; end
    tick(15);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tests++;
    if (uart_en !== 1'b0 || err_timeout !== 1'b1) begin
      fails++; $display("FAIL timeout_set_wins: uart_en %b err %b, required 0 and 1", uart_en, err_timeout);
    end
    wait_idle();
    tick(20);
    tests++;
    if (rx_wp !== base_rx || byte_cnt !== 16'd0) begin
      fails++; $display("FAIL timeout_dropped: frames %0d byte_cnt %0d, required 0 and 0", rx_wp - base_rx, byte_cnt);
    end
    tx_enable = 1'b0;
    tx_allow = 1'b1;
  endtask

  task automatic test_enable_gating;
    int base_rx, base_rq, n;
    apply_reset();
    base_rx = rx_wp; base_rq = rdreq_pulses;
    tx_enable = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    n = 0;
    while (send_sta_flg !== 1'b1 && n < 100) begin tick(1); n++; end
    tick(5);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL gate_in_busy: busy %b, required 1", busy); end
    tx_enable = 1'b0;
    wait_rx(base_rx + 1);
    wait_idle();
    tick(200);
    tests++;
    if (rdreq_pulses !== base_rq + 1 || busy !== 1'b0 || byte_cnt !== 16'd1 || rx_mem[base_rx % 64] !== 8'h11) begin
      fails++; $display("FAIL gate_hold: pulses %0d busy %b cnt %0d byte %h, required 1 0 1 11", rdreq_pulses - base_rq, busy, byte_cnt, rx_mem[base_rx % 64]);
    end
    tx_enable = 1'b1;
    wait_rx(base_rx + 3);
    wait_idle();
    tests++;
    if (rx_mem[(base_rx + 1) % 64] !== 8'h22 || rx_mem[(base_rx + 2) % 64] !== 8'h33 || byte_cnt !== 16'd3) begin
      fails++; $display("FAIL gate_resume: bytes %h %h cnt %0d, required 22 33 3", rx_mem[(base_rx + 1) % 64], rx_mem[(base_rx + 2) % 64], byte_cnt);
    end
    tx_enable = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int base_rx, n;
    apply_reset();
    base_rx = rx_wp;
    tx_enable = 1'b1;
    push(8'h44); push(8'h66);
    n = 0;
    while (send_sta_flg !== 1'b1 && n < 100) begin tick(1); n++; end
    tick(10);
    tests++;
    if (busy !== 1'b1 || byte_cnt !== 16'd1 || pd !== 8'h44) begin
      fails++; $display("FAIL midreset_pre: busy %b cnt %0d data %h, required 1 1 44", busy, byte_cnt, pd);
    end
    #2;
    rst = 1'b1;
    tx_enable = 1'b0;
    #1;
    tests++;
    if ({rdreq, uart_en, busy, err_timeout, pd, byte_cnt} !== 28'd0) begin
      fails++; $display("FAIL midreset_async: busy %b cnt %h data %h uart_en %b, required all 0", busy, byte_cnt, pd, uart_en);
    end
    tick(2);
    rst = 1'b0;
    n = 0;
    while (send_sta_flg !== 1'b0 && n < 2000) begin tick(1); n++; end
    tx_enable = 1'b1;
    wait_rx(base_rx + 2);
    wait_idle();
    tests++;
    if (rx_mem[base_rx % 64] !== 8'h44 || rx_mem[(base_rx + 1) % 64] !== 8'h66 || byte_cnt !== 16'd1) begin
      fails++; $display("FAIL midreset_resume: bytes %h %h cnt %0d, required 44 66 1", rx_mem[base_rx % 64], rx_mem[(base_rx + 1) % 64], byte_cnt);
    end
    tx_enable = 1'b0;
  endtask

  task automatic test_wrap;
    int base_rx;
    apply_reset();
    base_rx = rx_wp;
    force dut.r_byte_cnt = 16'hFFFF;
    tick(1);
    release dut.r_byte_cnt;
    tick(1);
    tests++;
    if (byte_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h, required ffff", byte_cnt); end
    tx_enable = 1'b1;
    push(8'h5A);
    wait_rx(base_rx + 1);
    wait_idle();
    tests++;
    if (byte_cnt !== 16'h0000 || rx_mem[base_rx % 64] !== 8'h5A) begin
      fails++; $display("FAIL wrap_count: cnt %h byte %h, required 0000 5a", byte_cnt, rx_mem[base_rx % 64]);
    end
    tx_enable = 1'b0;
  endtask

  task automatic test_latency2;
    int c, n;
    apply_reset();
    tx_enable2 = 1'b1;
    push2(8'hC7);
    n = 0;
    while (busy2 !== 1'b1 && n < 20) begin tick(1); n++; end
    tests++;
    if (rdreq2 !== 1'b1) begin fails++; $display("FAIL lat2_rdreq: got %b, required 1", rdreq2); end
    c = 1;
    while (uart_en2 !== 1'b1 && c < 20) begin tick(1); c++; end
    tests++;
    if (c !== 4) begin fails++; $display("FAIL lat2_latency: uart_en in cycle %0d, required 4", c); end
    tests++;
    if (pd2 !== 8'hC7) begin fails++; $display("FAIL lat2_data: got %h, required c7", pd2); end
    tick(2);
    flg2 = 1'b1;
    tick(3);
    flg2 = 1'b0;
    n = 0;
    while (busy2 !== 1'b0 && n < 100) begin tick(1); n++; end
    tests++;
    if (byte_cnt2 !== 16'd1 || uart_en2 !== 1'b0 || busy2 !== 1'b0 || err_timeout2 !== 1'b0) begin
      fails++; $display("FAIL lat2_done: cnt %0d uart_en %b busy %b err %b, required 1 0 0 0", byte_cnt2, uart_en2, busy2, err_timeout2);
    end
    tx_enable2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_enable_gating();
    test_reset_midframe();
    test_wrap();
    test_latency2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
